result_arbiter: RTL and testbench

RESULT_ARBITER -- requirements
Module: result_arbiter

---
 rtl/result_arbiter.sv | 139 +++++++++++++
 tb/tb_result_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/result_arbiter.sv
// result_arbiter
//   Four-requester arbiter with a single registered output slot. In each
//   accept slot (output empty, or consumer taking the held word) one valid
//   requester wins, its payload is registered into o_data and its index
//   into o_sel.
//
//   Winner selection:
//     default                  round-robin, search starts after last grant
//     RESULT_ARB_FIXED_PRIO_EN lowest-indexed valid requester wins
//
//   Ports:
//     clk          clock, rising edge
//     arstn        asynchronous active-low reset
//     i_req_valid  per-requester offer
//     i_data_0..3  requester payloads
//     o_req_ready  one-hot acceptance (combinational)
//     o_sel        index of the current / last grant
//     o_valid      output register holds unconsumed data
//     i_ready      consumer accepts o_data this cycle
//     o_data       registered winning payload
//
//   state | meaning
//   ------+-----------------------------------------
//   EMPTY | output slot free, o_valid=0
//   FULL  | output slot holds data, o_valid=1
module result_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [3:0]            i_req_valid,
    input  logic [DATA_WIDTH-1:0] i_data_0,
    input  logic [DATA_WIDTH-1:0] i_data_1,
    input  logic [DATA_WIDTH-1:0] i_data_2,
    input  logic [DATA_WIDTH-1:0] i_data_3,
    output logic [3:0]            o_req_ready,
    output logic [1:0]            o_sel,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  accept;
    logic                  grant;
    logic [1:0]            winner;
    logic [DATA_WIDTH-1:0] win_data;

`ifndef RESULT_ARB_FIXED_PRIO_EN
    logic [1:0] last_grant_q;
    logic [1:0] idx;
    logic       found;
`endif

    // Winner selection
    always_comb begin
        winner = 2'd0;
`ifdef RESULT_ARB_FIXED_PRIO_EN
        // Walk from highest to lowest so the lowest valid index is kept last.
        for (int k = 3; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                winner = 2'(k);
            end
        end
`else
        found = 1'b0;
        idx   = 2'd0;
        // Offsets 1..4 visit last_grant+1 .. last_grant (2-bit wrap).
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && i_req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        case (winner)
            2'd0:    win_data = i_data_0;
            2'd1:    win_data = i_data_1;
            2'd2:    win_data = i_data_2;
            default: win_data = i_data_3;
        endcase
    end

    // FSM next-state and acceptance. arstn gates the grant so o_req_ready
    // stays low for the whole reset, not just after the first edge.
    always_comb begin
        state_d     = state_q;
        accept      = (state_q == EMPTY) || i_ready;
        grant       = arstn && accept && (|i_req_valid);
        o_req_ready = 4'b0000;
        if (grant) begin
            o_req_ready = 4'b0001 << winner;
            state_d     = FULL;
        end else if (accept) begin
            state_d     = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_data <= '0;
            o_sel  <= 2'd0;
        end else if (grant) begin
            o_data <= win_data;
            o_sel  <= winner;
        end
    end

`ifndef RESULT_ARB_FIXED_PRIO_EN
    // Reset to 3 so the first search starts at requester 0.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            last_grant_q <= 2'd3;
        end else if (grant) begin
            last_grant_q <= winner;
        end
    end
`endif

    assign o_valid = (state_q == FULL);

endmodule

// File: tb/tb_result_arbiter.sv
module tb_result_arbiter;

    localparam int DW = 32;
    localparam logic [DW-1:0] D0 = 32'hA0A0_0000;
    localparam logic [DW-1:0] D1 = 32'hB1B1_1111;
    localparam logic [DW-1:0] D2 = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] D3 = 32'hC3C3_3333;
    localparam logic [DW-1:0] D0B = 32'h0123_4567;

    logic          clk;
    logic          arstn;
    logic [3:0]    i_req_valid;
    logic [DW-1:0] i_data_0, i_data_1, i_data_2, i_data_3;
    logic [3:0]    o_req_ready;
    logic [1:0]    o_sel;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]    valid;
        logic          ready;
        logic [3:0]    exp_rdy;
        logic          exp_valid;
        logic [1:0]    exp_sel;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    result_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_req_valid (i_req_valid),
        .i_data_0    (i_data_0),
        .i_data_1    (i_data_1),
        .i_data_2    (i_data_2),
        .i_data_3    (i_data_3),
        .o_req_ready (o_req_ready),
        .o_sel       (o_sel),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic r, input logic [3:0] er,
                       input logic ev, input logic [1:0] es, input logic [DW-1:0] ed);
        vec_t t;
        t.valid = v; t.ready = r; t.exp_rdy = er;
        t.exp_valid = ev; t.exp_sel = es; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    // Drive one cycle: check the combinational grant, then the registered result.
    task automatic step(input string tag, input vec_t t);
        @(negedge clk);
        i_req_valid = t.valid;
        i_ready     = t.ready;
        #1;
        chk({tag, " o_req_ready"}, DW'(o_req_ready), DW'(t.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, " o_valid"}, DW'(o_valid), DW'(t.exp_valid));
        chk({tag, " o_sel"},   DW'(o_sel),   DW'(t.exp_sel));
        chk({tag, " o_data"},  o_data,       t.exp_data);
    endtask

    initial begin
        vec_t h;

        arstn       = 1'b0;
        i_req_valid = 4'b1111;
        i_ready     = 1'b1;
        i_data_0    = D0;
        i_data_1    = D1;
        i_data_2    = D2;
        i_data_3    = D3;

`ifdef RESULT_ARB_FIXED_PRIO_EN
        add(4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        add(4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        add(4'b1010, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b1010, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b1010, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b1010, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b0000, 1, 4'b0000, 0, 2'd1, D1);
        add(4'b0000, 0, 4'b0000, 0, 2'd1, D1);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, D2);
        for (int i = 0; i < 5; i++) add(4'b0100, 0, 4'b0000, 1, 2'd2, D2);
        add(4'b0000, 1, 4'b0000, 0, 2'd2, D2);
        add(4'b1010, 0, 4'b0010, 1, 2'd1, D1);
        add(4'b1000, 1, 4'b1000, 1, 2'd3, D3);
        add(4'b0011, 0, 4'b0000, 1, 2'd3, D3);
        add(4'b0011, 1, 4'b0001, 1, 2'd0, D0);
`else
        add(4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        add(4'b1111, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b1111, 1, 4'b0100, 1, 2'd2, D2);
        add(4'b1111, 1, 4'b1000, 1, 2'd3, D3);
        add(4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        add(4'b0000, 1, 4'b0000, 0, 2'd0, D0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, D0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, D2);
        for (int i = 0; i < 5; i++) add(4'b0100, 0, 4'b0000, 1, 2'd2, D2);
        add(4'b0000, 1, 4'b0000, 0, 2'd2, D2);
        add(4'b1010, 0, 4'b1000, 1, 2'd3, D3);
        add(4'b1010, 1, 4'b0010, 1, 2'd1, D1);
        add(4'b1010, 1, 4'b1000, 1, 2'd3, D3);
        add(4'b0011, 0, 4'b0000, 1, 2'd3, D3);
        add(4'b0011, 1, 4'b0001, 1, 2'd0, D0);
`endif

        // Reset state, with all requesters asking
        #2;
        chk("reset o_valid",     DW'(o_valid),     '0);
        chk("reset o_sel",       DW'(o_sel),       '0);
        chk("reset o_data",      o_data,           '0);
        chk("reset o_req_ready", DW'(o_req_ready), '0);
        i_req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back transfer from FULL with fresh data on requester 0
        i_data_0 = D0B;
        h.valid = 4'b0001; h.ready = 1'b1; h.exp_rdy = 4'b0001;
        h.exp_valid = 1'b1; h.exp_sel = 2'd0; h.exp_data = D0B;
        step("b2b", h);

        // Stall with data held, then async reset mid-cycle
        h.valid = 4'b1111; h.ready = 1'b0; h.exp_rdy = 4'b0000;
        h.exp_valid = 1'b1; h.exp_sel = 2'd0; h.exp_data = D0B;
        step("stall", h);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        chk("async o_valid",     DW'(o_valid),     '0);
        chk("async o_sel",       DW'(o_sel),       '0);
        chk("async o_data",      o_data,           '0);
        chk("async o_req_ready", DW'(o_req_ready), '0);
        @(posedge clk);
        @(negedge clk);
        arstn       = 1'b1;
        i_req_valid = 4'b1111;
        i_ready     = 1'b1;
        #1;
        chk("post-reset o_req_ready", DW'(o_req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post-reset o_valid", DW'(o_valid), 32'h1);
        chk("post-reset o_sel",   DW'(o_sel),   32'h0);
        chk("post-reset o_data",  o_data,       D0B);

        h.valid = 4'b1111; h.ready = 1'b1; h.exp_valid = 1'b1;
`ifdef RESULT_ARB_FIXED_PRIO_EN
        h.exp_rdy = 4'b0001; h.exp_sel = 2'd0; h.exp_data = D0B;
`else
        h.exp_rdy = 4'b0010; h.exp_sel = 2'd1; h.exp_data = D1;
`endif
        step("post-reset 2nd", h);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
